// File: rtl/qnigma_nonce_chk.sv
// Anti-replay nonce checker: a 96-bit nonce is compared against the last accepted one
// over a shared 32-bit subtractor, then accepted or rejected against a sliding bitmap window.
module qnigma_nonce_chk #(
    parameter logic [95:0] NONCE_INI = 96'd1234,
    parameter int          WIN       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [95:0] non_in,
    input  logic        cmt,
    input  logic        abt,
    output logic        busy,
    output logic        done,
    output logic        acc,
    output logic        rej_dup,
    output logic        rej_old
);

    typedef enum logic [1:0] {IDLE, SUB, DEC, HOLD} state_t;

    state_t         state_q, state_d;
    logic [1:0]     widx_q;
    logic           borrow_q;
    logic [95:0]    last_q;
    logic [WIN-1:0] bitmap_q;

    logic [95:0]    non_q;
    logic [95:0]    d_q;
    logic           hold_ahead_q;
    logic           hold_small_q;
    logic [5:0]     hold_sh_q;

    logic [31:0]    sub_a, sub_b;
    logic [32:0]    sub_r;

    logic           d_zero, hi_ones, in_win, hit, ahead_small;
    logic [31:0]    off32;
    logic [WIN-1:0] off_mask;
    logic           v_acc, v_dup, v_old;

    function automatic logic [WIN-1:0] onehot(input logic [5:0] idx);
        onehot = WIN'(1) << idx;
    endfunction

    // Shared word subtractor: one 32-bit word of non_in - last per SUB cycle
    always_comb begin
        sub_a = non_q[31:0];
        sub_b = last_q[31:0];
        case (widx_q)
            2'd0:    begin sub_a = non_q[31:0];  sub_b = last_q[31:0];  end
            2'd1:    begin sub_a = non_q[63:32]; sub_b = last_q[63:32]; end
            default: begin sub_a = non_q[95:64]; sub_b = last_q[95:64]; end
        endcase
        sub_r = {1'b0, sub_a} - {1'b0, sub_b} - {32'd0, borrow_q};
    end

    // Verdict: a final borrow means the nonce lies behind last; only the low word
    // is needed to locate it inside the window since the upper words must be all ones.
    always_comb begin
        d_zero      = (d_q == 96'd0);
        hi_ones     = &d_q[95:32];
        off32       = 32'd0 - d_q[31:0];
        in_win      = hi_ones && (off32 < 32'(WIN));
        off_mask    = onehot(off32[5:0]);
        hit         = |(bitmap_q & off_mask);
        ahead_small = (d_q[95:32] == 64'd0) && (d_q[31:0] < 32'(WIN));
        v_acc       = (!borrow_q && !d_zero) || (borrow_q && in_win && !hit);
        v_dup       = d_zero || (borrow_q && in_win && hit);
        v_old       = borrow_q && !in_win;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req) state_d = SUB;
            SUB:  if (widx_q == 2'd2) state_d = DEC;
            DEC:  state_d = v_acc ? HOLD : IDLE;
            HOLD: if (cmt || abt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DEC);
        acc     = done && v_acc;
        rej_dup = done && v_dup;
        rej_old = done && v_old;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            widx_q   <= 2'd0;
            borrow_q <= 1'b0;
            last_q   <= NONCE_INI;
            bitmap_q <= WIN'(1);
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req) begin
                    widx_q   <= 2'd0;
                    borrow_q <= 1'b0;
                end
                SUB: begin
                    widx_q   <= widx_q + 2'd1;
                    borrow_q <= sub_r[32];
                end
                HOLD: if (cmt && !abt) begin
                    if (hold_ahead_q) begin
                        last_q   <= non_q;
                        bitmap_q <= hold_small_q ? ((bitmap_q << hold_sh_q) | WIN'(1)) : WIN'(1);
                    end else begin
                        bitmap_q <= bitmap_q | onehot(hold_sh_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers carry no reset; they are only consumed under FSM control
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req)
            non_q <= non_in;
        if (state_q == SUB) begin
            case (widx_q)
                2'd0:    d_q[31:0]  <= sub_r[31:0];
                2'd1:    d_q[63:32] <= sub_r[31:0];
                default: d_q[95:64] <= sub_r[31:0];
            endcase
        end
        if (state_q == DEC) begin
            hold_ahead_q <= !borrow_q;
            hold_small_q <= ahead_small;
            hold_sh_q    <= borrow_q ? off32[5:0] : d_q[5:0];
        end
    end

endmodule

// File: tb/tb_qnigma_nonce_chk.sv
// Directed bench for qnigma_nonce_chk with NONCE_INI=1234, WIN=32.
module tb_qnigma_nonce_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [95:0] non_in = 96'd0;
    logic        cmt = 1'b0;
    logic        abt = 1'b0;
    logic        busy, done, acc, rej_dup, rej_old;

    int vec = 0;
    int err = 0;

    localparam logic [3:0] V_ACC = 4'b1100;
    localparam logic [3:0] V_DUP = 4'b1010;
    localparam logic [3:0] V_OLD = 4'b1001;
    localparam logic [95:0] ALL1 = {96{1'b1}};

    qnigma_nonce_chk #(.NONCE_INI(96'd1234), .WIN(32)) dut (
        .clk(clk), .rst(rst), .req(req), .non_in(non_in), .cmt(cmt), .abt(abt),
        .busy(busy), .done(done), .acc(acc), .rej_dup(rej_dup), .rej_old(rej_old)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue req in the current cycle N and return {done,acc,rej_dup,rej_old} at N+4
    task automatic send(input logic [95:0] n, output logic [3:0] v, output logic pre);
        req = 1'b1;
        non_in = n;
        tick;
        req = 1'b0;
        tick;
        tick;
        pre = done;
        tick;
        v = {done, acc, rej_dup, rej_old};
    endtask

    // From the DEC cycle: step into HOLD, drive cmt/abt for one cycle, land in IDLE
    task automatic decide(input logic c, input logic a);
        tick;
        cmt = c;
        abt = a;
        tick;
        cmt = 1'b0;
        abt = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        vec++; if ({busy, done, acc, rej_dup, rej_old} !== 5'b0) begin
            err++; $display("FAIL reset_outs: got %b want 00000", {busy, done, acc, rej_dup, rej_old});
        end
        vec++; if (dut.last_q !== 96'd1234) begin
            err++; $display("FAIL reset_last: got %0d want 1234", dut.last_q);
        end
        vec++; if (dut.bitmap_q !== 32'h1) begin
            err++; $display("FAIL reset_bitmap: got %h want 00000001", dut.bitmap_q);
        end
    endtask

    task automatic test_ahead;
        logic [3:0] v;
        logic pre;
        req = 1'b1;
        non_in = 96'd1235;
        tick;
        req = 1'b0;
        vec++; if (busy !== 1'b1) begin
            err++; $display("FAIL busy_n1: got %b want 1", busy);
        end
        tick;
        tick;
        pre = done;
        tick;
        v = {done, acc, rej_dup, rej_old};
        vec++; if (pre !== 1'b0) begin
            err++; $display("FAIL done_early: got %b want 0", pre);
        end
        vec++; if (v !== V_ACC) begin
            err++; $display("FAIL ahead_1235: got %b want %b", v, V_ACC);
        end
        decide(1'b1, 1'b0);
        vec++; if (busy !== 1'b0) begin
            err++; $display("FAIL busy_after_cmt: got %b want 0", busy);
        end
        vec++; if (dut.last_q !== 96'd1235 || dut.bitmap_q !== 32'h3) begin
            err++; $display("FAIL cmt_1235: got last %0d bm %h want 1235 00000003", dut.last_q, dut.bitmap_q);
        end
        send(96'd1235, v, pre);
        vec++; if (v !== V_DUP) begin
            err++; $display("FAIL dup_1235: got %b want %b", v, V_DUP);
        end
        tick;
        vec++; if (busy !== 1'b0) begin
            err++; $display("FAIL busy_after_rej: got %b want 0", busy);
        end
    endtask

    task automatic test_behind;
        logic [3:0] v;
        logic pre;
        send(96'd1230, v, pre);
        vec++; if (v !== V_ACC) begin
            err++; $display("FAIL behind_1230: got %b want %b", v, V_ACC);
        end
        decide(1'b1, 1'b0);
        vec++; if (dut.last_q !== 96'd1235 || dut.bitmap_q !== 32'h23) begin
            err++; $display("FAIL cmt_1230: got last %0d bm %h want 1235 00000023", dut.last_q, dut.bitmap_q);
        end
        send(96'd1230, v, pre);
        vec++; if (v !== V_DUP) begin
            err++; $display("FAIL dup_1230: got %b want %b", v, V_DUP);
        end
        tick;
        send(96'd1203, v, pre);
        vec++; if (v !== V_OLD) begin
            err++; $display("FAIL old_1203: got %b want %b", v, V_OLD);
        end
        tick;
    endtask

    task automatic test_borrow;
        logic [3:0] v;
        logic pre;
        send(96'h1_0000_0000, v, pre);
        vec++; if (v !== V_ACC) begin
            err++; $display("FAIL ahead_2p32: got %b want %b", v, V_ACC);
        end
        decide(1'b1, 1'b0);
        vec++; if (dut.last_q !== 96'h1_0000_0000 || dut.bitmap_q !== 32'h1) begin
            err++; $display("FAIL cmt_2p32: got last %h bm %h want 100000000 00000001", dut.last_q, dut.bitmap_q);
        end
        send(96'h0_FFFF_FFFF, v, pre);
        vec++; if (v !== V_ACC) begin
            err++; $display("FAIL behind_off1: got %b want %b", v, V_ACC);
        end
        decide(1'b1, 1'b0);
        vec++; if (dut.last_q !== 96'h1_0000_0000 || dut.bitmap_q !== 32'h3) begin
            err++; $display("FAIL cmt_off1: got last %h bm %h want 100000000 00000003", dut.last_q, dut.bitmap_q);
        end
    endtask

    task automatic test_handshake;
        logic [3:0] v;
        logic pre;
        send(96'h1_0000_0002, v, pre);
        vec++; if (v !== V_ACC) begin
            err++; $display("FAIL hs_acc1: got %b want %b", v, V_ACC);
        end
        decide(1'b0, 1'b1);
        vec++; if (dut.last_q !== 96'h1_0000_0000 || dut.bitmap_q !== 32'h3) begin
            err++; $display("FAIL abt_state: got last %h bm %h want 100000000 00000003", dut.last_q, dut.bitmap_q);
        end
        send(96'h1_0000_0002, v, pre);
        vec++; if (v !== V_ACC) begin
            err++; $display("FAIL hs_acc2: got %b want %b", v, V_ACC);
        end
        decide(1'b1, 1'b1);
        vec++; if (dut.last_q !== 96'h1_0000_0000 || dut.bitmap_q !== 32'h3) begin
            err++; $display("FAIL cmt_abt_state: got last %h bm %h want 100000000 00000003", dut.last_q, dut.bitmap_q);
        end
        // req during SUB carrying a duplicate must not disturb the pending check
        req = 1'b1;
        non_in = 96'h1_0000_0002;
        tick;
        non_in = 96'h1_0000_0000;
        tick;
        req = 1'b0;
        tick;
        tick;
        v = {done, acc, rej_dup, rej_old};
        vec++; if (v !== V_ACC) begin
            err++; $display("FAIL req_in_sub: got %b want %b", v, V_ACC);
        end
        tick;
        req = 1'b1;
        tick;
        req = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        vec++; if (busy !== 1'b1 || done !== 1'b0) begin
            err++; $display("FAIL hold_wait: got busy %b done %b want 1 0", busy, done);
        end
        cmt = 1'b1;
        tick;
        cmt = 1'b0;
        vec++; if (busy !== 1'b0 || dut.last_q !== 96'h1_0000_0002 || dut.bitmap_q !== 32'hD) begin
            err++; $display("FAIL hold_cmt: got busy %b last %h bm %h want 0 100000002 0000000d", busy, dut.last_q, dut.bitmap_q);
        end
        cmt = 1'b1;
        tick;
        cmt = 1'b0;
        vec++; if (busy !== 1'b0 || dut.last_q !== 96'h1_0000_0002 || dut.bitmap_q !== 32'hD) begin
            err++; $display("FAIL cmt_idle: got busy %b last %h bm %h want 0 100000002 0000000d", busy, dut.last_q, dut.bitmap_q);
        end
    endtask

    task automatic test_rst_mid;
        logic [3:0] v;
        logic pre;
        req = 1'b1;
        non_in = 96'h1_0000_0003;
        tick;
        req = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vec++; if (busy !== 1'b0 || done !== 1'b0 || dut.last_q !== 96'd1234 || dut.bitmap_q !== 32'h1) begin
            err++; $display("FAIL rst_sub: got busy %b done %b last %h bm %h want 0 0 4d2 00000001", busy, done, dut.last_q, dut.bitmap_q);
        end
        send(96'd1240, v, pre);
        vec++; if (v !== V_ACC) begin
            err++; $display("FAIL acc_1240: got %b want %b", v, V_ACC);
        end
        tick;
        rst = 1'b1;
        cmt = 1'b1;
        tick;
        rst = 1'b0;
        cmt = 1'b0;
        vec++; if (busy !== 1'b0 || done !== 1'b0 || dut.last_q !== 96'd1234 || dut.bitmap_q !== 32'h1) begin
            err++; $display("FAIL rst_hold: got busy %b done %b last %h bm %h want 0 0 4d2 00000001", busy, done, dut.last_q, dut.bitmap_q);
        end
    endtask

    task automatic test_stream;
        logic [3:0] v;
        logic pre;
        for (int i = 0; i < 40; i++) begin
            send(96'd1235 + 96'(i), v, pre);
            vec++; if (v !== V_ACC) begin
                err++; $display("FAIL stream_%0d: got %b want %b", 1235 + i, v, V_ACC);
            end
            decide(1'b1, 1'b0);
        end
        vec++; if (dut.last_q !== 96'd1274 || dut.bitmap_q !== 32'hFFFF_FFFF) begin
            err++; $display("FAIL stream_end: got last %0d bm %h want 1274 ffffffff", dut.last_q, dut.bitmap_q);
        end
    endtask

    task automatic test_wrap;
        logic [3:0] v;
        logic pre;
        send(ALL1, v, pre);
        vec++; if (v !== V_ACC) begin
            err++; $display("FAIL wrap_max: got %b want %b", v, V_ACC);
        end
        decide(1'b1, 1'b0);
        send(ALL1 - 96'd3, v, pre);
        vec++; if (v !== V_ACC) begin
            err++; $display("FAIL wrap_off3: got %b want %b", v, V_ACC);
        end
        decide(1'b1, 1'b0);
        vec++; if (dut.last_q !== ALL1 || dut.bitmap_q !== 32'h9) begin
            err++; $display("FAIL wrap_state: got last %h bm %h want all-ones 00000009", dut.last_q, dut.bitmap_q);
        end
        send(96'd5, v, pre);
        vec++; if (v !== V_OLD) begin
            err++; $display("FAIL wrap_small: got %b want %b", v, V_OLD);
        end
        tick;
    endtask

    initial begin
        tick;
        test_reset;
        test_ahead;
        test_behind;
        test_borrow;
        test_handshake;
        test_rst_mid;
        test_stream;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
